// File: rtl/conv_kxk_mc.sv
// Multi-channel KxK convolution: accumulates IN_CH window beats plus bias into one result.
// Define CONV_KXK_RELU_EN to clamp negative results to zero on the way to conv_value.

module conv_kxk_mc_tap #(
   parameter int BIT_WIDTH = 8,
   parameter int OUT_WIDTH = 32
) (
   input  logic [BIT_WIDTH-1:0] pix,
   input  logic [BIT_WIDTH-1:0] wgt,
   output logic [OUT_WIDTH-1:0] prod
);
   logic signed [2*BIT_WIDTH-1:0] p;

   assign p    = $signed(pix) * $signed(wgt);
   assign prod = OUT_WIDTH'(p);
endmodule

module conv_kxk_mc #(
   parameter int BIT_WIDTH = 8,
   parameter int OUT_WIDTH = 32,
   parameter int K         = 3,
   parameter int IN_CH     = 6,
   localparam int TAPS     = K * K,
   localparam int CW       = (IN_CH > 1) ? $clog2(IN_CH) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [TAPS*BIT_WIDTH-1:0] pix,
   input  logic [TAPS*BIT_WIDTH-1:0] wgt,
   input  logic [BIT_WIDTH-1:0]      bias,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [OUT_WIDTH-1:0]      conv_value,
   output logic [CW-1:0]             ch_idx
);
   logic [TAPS-1:0][OUT_WIDTH-1:0] prod;
   logic [OUT_WIDTH-1:0]           sum_c, bias_ext, acc_next, res_c;
   logic [OUT_WIDTH-1:0]           acc_q, acc_d, conv_value_q, conv_value_d;
   logic [CW-1:0]                  ch_idx_q, ch_idx_d;
   logic                           out_valid_q, out_valid_d;
   logic                           accept, last;

   for (genvar i = 0; i < TAPS; i++) begin : g_tap
      conv_kxk_mc_tap #(.BIT_WIDTH(BIT_WIDTH), .OUT_WIDTH(OUT_WIDTH)) u_tap (
         .pix  (pix[i*BIT_WIDTH +: BIT_WIDTH]),
         .wgt  (wgt[i*BIT_WIDTH +: BIT_WIDTH]),
         .prod (prod[i])
      );
   end

   always_comb begin
      sum_c = '0;
      for (int i = 0; i < TAPS; i++) sum_c = sum_c + prod[i];
   end

   assign bias_ext = OUT_WIDTH'($signed(bias));
   assign acc_next = ((ch_idx_q == '0) ? bias_ext : acc_q) + sum_c;

`ifdef CONV_KXK_RELU_EN
   assign res_c = acc_next[OUT_WIDTH-1] ? '0 : acc_next;
`else
   assign res_c = acc_next;
`endif

   // A single ready rule for every beat keeps the channel counter and output slot in lockstep.
   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;
   assign last     = (ch_idx_q == CW'(IN_CH - 1));

   always_comb begin
      acc_d        = acc_q;
      ch_idx_d     = ch_idx_q;
      conv_value_d = conv_value_q;
      out_valid_d  = out_valid_q;
      if (out_valid_q && out_ready) out_valid_d = 1'b0;
      if (accept) begin
         if (last) begin
            conv_value_d = res_c;
            out_valid_d  = 1'b1;
            ch_idx_d     = '0;
         end else begin
            acc_d    = acc_next;
            ch_idx_d = CW'(ch_idx_q + 1'b1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q        <= '0;
         ch_idx_q     <= '0;
         conv_value_q <= '0;
         out_valid_q  <= 1'b0;
      end else begin
         acc_q        <= acc_d;
         ch_idx_q     <= ch_idx_d;
         conv_value_q <= conv_value_d;
         out_valid_q  <= out_valid_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign conv_value = conv_value_q;
   assign ch_idx     = ch_idx_q;
endmodule
